// File: rtl/fir512_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir512_pkg                                                   |
// | Description : Shared widths, defaults and FSM state type for fir512_mac.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package fir512_pkg;

    localparam int TAPS   = 512;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 41;
    localparam int SHIFT  = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fir512_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir512_sat                                                   |
// | Description : Arithmetic right shift of the accumulator, clamp to 16 bits. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fir512_sat #(
    parameter int SHIFT = fir512_pkg::SHIFT
) (
    input  logic signed [fir512_pkg::ACC_W-1:0]  i_acc,
    output logic        [fir512_pkg::DATA_W-1:0] o_data
);
    import fir512_pkg::*;

    localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(-(2 ** (DATA_W - 1)));

    logic signed [ACC_W-1:0] w_shifted;

    // >>> on a signed operand floors toward minus infinity
    assign w_shifted = i_acc >>> SHIFT;

    always_comb begin
        o_data = w_shifted[DATA_W-1:0];
        if (w_shifted > c_sat_max) begin
            o_data = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (w_shifted < c_sat_min) begin
            o_data = {1'b1, {(DATA_W - 1){1'b0}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir512_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir512_mac                                                   |
// | Description : Single-MAC FIR filter over external history/coef RAMs.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fir512_mac #(
    parameter int TAPS  = fir512_pkg::TAPS,
    parameter int SHIFT = fir512_pkg::SHIFT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [fir512_pkg::DATA_W-1:0] in_data,
    output logic                          hist_wr_ce,
    output logic [fir512_pkg::ADDR_W-1:0] hist_wr_addr,
    output logic [fir512_pkg::DATA_W-1:0] hist_wr_data,
    output logic                          hist_rd_ce,
    output logic [fir512_pkg::ADDR_W-1:0] hist_rd_addr,
    input  logic [fir512_pkg::DATA_W-1:0] hist_rd_data,
    output logic                          coef_rd_ce,
    output logic [fir512_pkg::ADDR_W-1:0] coef_rd_addr,
    input  logic [fir512_pkg::DATA_W-1:0] coef_rd_data,
    output logic                          out_valid,
    output logic [fir512_pkg::DATA_W-1:0] out_data,
    output logic                          busy
);
    import fir512_pkg::*;

    localparam logic [ADDR_W-1:0] c_last_tap = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] c_taps     = ADDR_W'(TAPS);

    state_t                   r_state, w_state_nxt;
    logic                     w_accept;
    logic                     w_run;
    logic [ADDR_W-1:0]        r_wr_ptr, r_base, r_tap, w_hist_addr;
    logic [1:0]               r_drain_cnt;
    logic                     r_rd_vld, r_prod_vld;
    logic signed [PROD_W-1:0] w_coef_ext, w_hist_ext, r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0]        w_sat;
    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_out_data;

    // Ring index base-k; for TAPS=512 the 9-bit wrap already gives mod 512
    assign w_hist_addr = (r_base >= r_tap) ? (r_base - r_tap) : (r_base + c_taps - r_tap);
    assign w_coef_ext  = {{(PROD_W - DATA_W){coef_rd_data[DATA_W-1]}}, coef_rd_data};
    assign w_hist_ext  = {{(PROD_W - DATA_W){hist_rd_data[DATA_W-1]}}, hist_rd_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_run        = 1'b0;
        in_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                busy     = 1'b0;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                w_run = 1'b1;
                if (r_tap == c_last_tap) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_drain_cnt == 2'd2) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept     = in_ready & in_valid;
    assign hist_wr_ce   = w_accept;
    assign hist_wr_addr = r_wr_ptr;
    assign hist_wr_data = in_data;
    assign hist_rd_ce   = w_run;
    assign hist_rd_addr = w_hist_addr;
    assign coef_rd_ce   = w_run;
    assign coef_rd_addr = r_tap;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;

    fir512_sat #(
        .SHIFT (SHIFT)
    ) u_sat (
        .i_acc  (r_acc),
        .o_data (w_sat)
    );

    // Read data lands one cycle after the address, product one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_base      <= '0;
            r_tap       <= '0;
            r_drain_cnt <= '0;
            r_rd_vld    <= 1'b0;
            r_prod_vld  <= 1'b0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_base   <= r_wr_ptr;
                r_wr_ptr <= (r_wr_ptr == c_last_tap) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_run) begin
                r_tap <= (r_tap == c_last_tap) ? '0 : r_tap + 1'b1;
            end else begin
                r_tap <= '0;
            end
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            r_rd_vld    <= w_run;
            r_prod_vld  <= r_rd_vld;
            if (r_rd_vld) begin
                r_prod <= w_coef_ext * w_hist_ext;
            end
            if (w_accept) begin
                r_acc <= '0;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
            end
            r_out_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                r_out_data <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir512_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir512_mac                                                |
// | Description : Directed self-checking bench for fir512_mac with RAM models. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_fir512_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        hist_wr_ce, hist_rd_ce, coef_rd_ce;
    logic [8:0]  hist_wr_addr, hist_rd_addr, coef_rd_addr;
    logic [15:0] hist_wr_data, hist_rd_data, coef_rd_data;
    logic        out_valid, busy;
    logic [15:0] out_data;

    logic        in_valid_s, in_ready_s;
    logic [15:0] in_data_s;
    logic        hist_wr_ce_s, hist_rd_ce_s, coef_rd_ce_s;
    logic [8:0]  hist_wr_addr_s, hist_rd_addr_s, coef_rd_addr_s;
    logic [15:0] hist_wr_data_s, out_data_s;
    logic [15:0] rd_zero_s = 16'h0000;
    logic        out_valid_s, busy_s;

    logic [15:0] hist_mem [512];
    logic [15:0] coef_mem [512];
    logic        fill_en = 1'b0;
    logic [15:0] fill_val = 16'h0000;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fir512_mac u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .hist_wr_ce(hist_wr_ce), .hist_wr_addr(hist_wr_addr), .hist_wr_data(hist_wr_data),
        .hist_rd_ce(hist_rd_ce), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
        .coef_rd_ce(coef_rd_ce), .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
        .out_valid(out_valid), .out_data(out_data), .busy(busy)
    );

    // Small instance makes the write-pointer wrap reachable in a few hundred cycles
    fir512_mac #(.TAPS(8)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
        .hist_wr_ce(hist_wr_ce_s), .hist_wr_addr(hist_wr_addr_s), .hist_wr_data(hist_wr_data_s),
        .hist_rd_ce(hist_rd_ce_s), .hist_rd_addr(hist_rd_addr_s), .hist_rd_data(rd_zero_s),
        .coef_rd_ce(coef_rd_ce_s), .coef_rd_addr(coef_rd_addr_s), .coef_rd_data(rd_zero_s),
        .out_valid(out_valid_s), .out_data(out_data_s), .busy(busy_s)
    );

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 512; i++) hist_mem[i] <= fill_val;
        end else if (hist_wr_ce) begin
            hist_mem[hist_wr_addr] <= hist_wr_data;
        end
        if (hist_rd_ce) hist_rd_data <= hist_mem[hist_rd_addr];
        if (coef_rd_ce) coef_rd_data <= coef_mem[coef_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_coef(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                            input logic [15:0] c3, input logic [15:0] rest);
        for (int i = 0; i < 512; i++) coef_mem[i] = rest;
        coef_mem[0] = c0;
        coef_mem[1] = c1;
        coef_mem[2] = c2;
        coef_mem[3] = c3;
    endtask

    task automatic fill_hist(input logic [15:0] v);
        @(posedge clk); #1;
        fill_val = v;
        fill_en  = 1'b1;
        @(posedge clk); #1;
        fill_en  = 1'b0;
    endtask

    task automatic run_sample(input string tag, input logic [15:0] s, input logic [15:0] exp,
                              input logic [8:0] exp_base, input bit detail);
        int         cnt;
        logic [8:0] prev = exp_base - 9'd1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = s;
        @(negedge clk);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_wr_addr"}, 32'(hist_wr_addr), 32'(exp_base));
        if (detail) check({tag, "_wr_ce"}, 32'(hist_wr_ce), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (cnt = 0; cnt < 600; cnt++) begin
            @(negedge clk);
            if (detail && cnt == 0) begin
                check({tag, "_run0_rd_addr"}, 32'(hist_rd_addr), 32'(exp_base));
                check({tag, "_run0_busy"}, 32'(busy), 32'd1);
                check({tag, "_run0_ready"}, 32'(in_ready), 32'd0);
                check({tag, "_run0_wr_ce"}, 32'(hist_wr_ce), 32'd0);
            end
            if (detail && cnt == 1) check({tag, "_run1_rd_addr"}, 32'(hist_rd_addr), 32'(prev));
            if (detail && cnt == 511) begin
                check({tag, "_run511_coef_addr"}, 32'(coef_rd_addr), 32'd511);
                check({tag, "_run511_ce"}, 32'(hist_rd_ce), 32'd1);
            end
            if (detail && cnt == 512) begin
                check({tag, "_drain_ce"}, 32'({hist_rd_ce, coef_rd_ce}), 32'd0);
                check({tag, "_drain_busy"}, 32'(busy), 32'd1);
            end
            if (out_valid) break;
            @(posedge clk);
        end
        check({tag, "_latency"}, 32'(cnt), 32'd516);
        check({tag, "_out"}, 32'(out_data), 32'(exp));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(out_valid), 32'd0);
        check({tag, "_hold"}, 32'(out_data), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_acc [9];
        logic [8:0] a_acc [9];
        int  nacc;
        bit  seen;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'h0000;
        in_valid_s = 1'b0;
        in_data_s  = 16'h0000;
        set_coef(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0);
        fill_hist(16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_ce", 32'({hist_wr_ce, hist_rd_ce, coef_rd_ce}), 32'd0);

        run_sample("single", 16'h1234, 16'h1233, 9'd0, 1'b1);

        set_coef(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0);
        run_sample("floor", 16'hFFFF, 16'hFFFF, 9'd1, 1'b0);

        fill_hist(16'h0000);
        set_coef(16'h7FFF, 16'h4000, 16'h8000, 16'h0001, 16'h0);
        run_sample("imp0", 16'h7FFF, 16'h7FFE, 9'd2, 1'b0);
        run_sample("imp1", 16'h0000, 16'h3FFF, 9'd3, 1'b0);
        run_sample("imp2", 16'h0000, 16'h8001, 9'd4, 1'b0);
        run_sample("imp3", 16'h0000, 16'h0000, 9'd5, 1'b0);

        fill_hist(16'h8000);
        set_coef(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_sample("sat_neg", 16'h8000, 16'h8000, 9'd6, 1'b0);
        set_coef(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        run_sample("sat_pos", 16'h8000, 16'h7FFF, 9'd7, 1'b0);

        // Back-to-back demand: accepts must be exactly one full transaction apart
        set_coef(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0);
        t_acc = '{default: 0};
        nacc  = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'h0100;
        for (int c = 0; c < 1200 && nacc < 2; c++) begin
            @(negedge clk);
            if (in_ready) begin
                t_acc[nacc] = c;
                nacc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("cont_accepts", 32'(nacc), 32'd2);
        check("cont_spacing", 32'(t_acc[1] - t_acc[0]), 32'd517);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("cont_drained", 32'(busy), 32'd0);

        t_acc = '{default: 0};
        a_acc = '{default: 9'd0};
        nacc  = 0;
        @(posedge clk); #1;
        in_valid_s = 1'b1;
        in_data_s  = 16'h0055;
        for (int c = 0; c < 300 && nacc < 9; c++) begin
            @(negedge clk);
            if (in_ready_s) begin
                t_acc[nacc] = c;
                a_acc[nacc] = hist_wr_addr_s;
                nacc++;
            end
            @(posedge clk); #1;
        end
        in_valid_s = 1'b0;
        check("wrap_accepts", 32'(nacc), 32'd9);
        check("wrap_spacing", 32'(t_acc[1] - t_acc[0]), 32'd13);
        check("wrap_addr7", 32'(a_acc[7]), 32'd7);
        check("wrap_addr8", 32'(a_acc[8]), 32'd0);

        // Abort a transaction in RUN cycle 200
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_ce", 32'({hist_rd_ce, coef_rd_ce}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out", 32'(seen), 32'd0);
        run_sample("post_rst", 16'h0100, 16'h00FF, 9'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
